// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, stall, bubble and flush control for a 5-stage pipe
module hazard_controller #(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int MC_LAT   = 4,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*REG_W-1:0] IF_ID_rs,
    input  logic [NUM_SRC-1:0]       IF_ID_rsUsed,
    input  logic [NUM_SRC*REG_W-1:0] ID_EX_rs,
    input  logic [REG_W-1:0]         ID_EX_rd,
    input  logic                     regWrite_ID_EX,
    input  logic                     load_ID_EX,
    input  logic                     multiCycle_ID_EX,
    input  logic [REG_W-1:0]         EX_MEM_rd,
    input  logic [REG_W-1:0]         MEM_WB_rd,
    input  logic                     regWrite_EX_MEM,
    input  logic                     regWrite_MEM_WB,
    input  logic                     branchTaken_EX,
    input  logic                     memReady,
    output logic [2*NUM_SRC-1:0]     forwardOp,
    output logic                     stall_PC,
    output logic                     stall_IF_ID,
    output logic                     stall_ID_EX,
    output logic                     stall_EX_MEM,
    output logic                     bubble_ID_EX,
    output logic                     bubble_EX_MEM,
    output logic                     flush_IF_ID,
    output logic [CNT_W-1:0]         stallCycles
);

    localparam int MAX_LAT = (LOAD_LAT > MC_LAT) ? LOAD_LAT : MC_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam bit MC_EN   = (MC_LAT > 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] MC_INIT   = CW'((MC_LAT >= 2) ? MC_LAT - 2 : 0);

    typedef enum logic [1:0] {IDLE, LOAD_STALL, MC_BUSY, MC_LAST} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic [CNT_W-1:0]    stall_count;
    logic [2*NUM_SRC-1:0] fwd;
    logic                rs_hit, load_use, mc_start;
    logic                s_pc, s_if_id, s_id_ex, s_ex_mem, b_id_ex, b_ex_mem, fl_if_id;

    always_comb begin
        fwd = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (regWrite_EX_MEM && (EX_MEM_rd != '0) && (EX_MEM_rd == ID_EX_rs[i*REG_W +: REG_W]))
                fwd[2*i +: 2] = 2'b01;
            else if (regWrite_MEM_WB && (MEM_WB_rd != '0) && (MEM_WB_rd == ID_EX_rs[i*REG_W +: REG_W]))
                fwd[2*i +: 2] = 2'b10;
        end
    end

    always_comb begin
        rs_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (IF_ID_rsUsed[i] && (IF_ID_rs[i*REG_W +: REG_W] == ID_EX_rd))
                rs_hit = 1'b1;
        end
    end

    assign load_use = load_ID_EX && regWrite_ID_EX && (ID_EX_rd != '0) && rs_hit;
    assign mc_start = MC_EN && multiCycle_ID_EX;

    // Memory freeze overrides everything and holds state; otherwise MC > branch > load-use.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        s_pc       = 1'b0;
        s_if_id    = 1'b0;
        s_id_ex    = 1'b0;
        s_ex_mem   = 1'b0;
        b_id_ex    = 1'b0;
        b_ex_mem   = 1'b0;
        fl_if_id   = 1'b0;
        if (!memReady) begin
            s_pc     = 1'b1;
            s_if_id  = 1'b1;
            s_id_ex  = 1'b1;
            s_ex_mem = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (mc_start) begin
                        s_pc     = 1'b1;
                        s_if_id  = 1'b1;
                        s_id_ex  = 1'b1;
                        b_ex_mem = 1'b1;
                        if (MC_LAT == 2) begin
                            state_next = MC_LAST;
                        end else begin
                            state_next = MC_BUSY;
                            cnt_next   = MC_INIT;
                        end
                    end else if (branchTaken_EX) begin
                        fl_if_id = 1'b1;
                        b_id_ex  = 1'b1;
                    end else if (load_use) begin
                        s_pc    = 1'b1;
                        s_if_id = 1'b1;
                        b_id_ex = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_next = LOAD_STALL;
                            cnt_next   = LOAD_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    if (branchTaken_EX) begin
                        fl_if_id   = 1'b1;
                        b_id_ex    = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        s_pc     = 1'b1;
                        s_if_id  = 1'b1;
                        b_id_ex  = 1'b1;
                        cnt_next = cnt - CNT_ONE;
                        if (cnt == CNT_ONE)
                            state_next = IDLE;
                    end
                end
                MC_BUSY: begin
                    s_pc     = 1'b1;
                    s_if_id  = 1'b1;
                    s_id_ex  = 1'b1;
                    b_ex_mem = 1'b1;
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state_next = MC_LAST;
                end
                MC_LAST: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (s_pc && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Reset forces every control output low combinationally, not just after a clock.
    assign forwardOp     = rst_n ? fwd : '0;
    assign stall_PC      = rst_n & s_pc;
    assign stall_IF_ID   = rst_n & s_if_id;
    assign stall_ID_EX   = rst_n & s_id_ex;
    assign stall_EX_MEM  = rst_n & s_ex_mem;
    assign bubble_ID_EX  = rst_n & b_id_ex;
    assign bubble_EX_MEM = rst_n & b_ex_mem;
    assign flush_IF_ID   = rst_n & fl_if_id;
    assign stallCycles   = stall_count;

endmodule
